// File: rtl/core_pkg.sv
// Shared types and SRAM geometry for the corelet controller.
// Imported by the controller top and its output write port.
package core_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_EXEC_A,
      S_DRAIN,
      S_DONE
   } state_e;

   localparam int unsigned I_ROWS = 108;
   localparam int unsigned I_DW   = 32;
   localparam int unsigned I_AW   = 7;
   localparam int unsigned O_ROWS = 16;
   localparam int unsigned O_DW   = 128;
   localparam int unsigned O_AW   = 4;
   localparam int unsigned O_CW   = 5;

   localparam logic EN_ON  = 1'b0;
   localparam logic EN_OFF = 1'b1;

endpackage

// File: rtl/o_wr_port.sv
// Result capture: registers one array row per accepted valid
// and drives it into the output SRAM on the following cycle.
module o_wr_port
   import core_pkg::*;
#(
   parameter int unsigned O_LEN = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr_i,
   input  logic            en_i,
   input  logic            vld_i,
   input  logic [O_DW-1:0] data_i,
   output logic            full_o,
   output logic [O_DW-1:0] od_o,
   output logic [O_AW-1:0] oaddr_o,
   output logic            ocen_o,
   output logic            owen_o
);

   localparam logic [O_CW-1:0] LEN = O_CW'(O_LEN);

   logic [O_CW-1:0] cnt_q, cnt_d;
   logic [O_DW-1:0] od_q, od_d;
   logic [O_AW-1:0] addr_q, addr_d;
   logic            cen_q, cen_d;
   logic            take;

   assign take = en_i & vld_i & (cnt_q < LEN);

   // accept a row only while capture is enabled and rows remain
   always_comb begin
      cnt_d  = cnt_q;
      od_d   = od_q;
      addr_d = addr_q;
      cen_d  = EN_OFF;
      if (clr_i) begin
         cnt_d = '0;
      end else if (take) begin
         cnt_d  = cnt_q + 1'b1;
         od_d   = data_i;
         addr_d = cnt_q[O_AW-1:0];
         cen_d  = EN_ON;
      end
   end

   // capture registers; reset drops any pending write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         od_q   <= '0;
         addr_q <= '0;
         cen_q  <= EN_OFF;
      end else begin
         cnt_q  <= cnt_d;
         od_q   <= od_d;
         addr_q <= addr_d;
         cen_q  <= cen_d;
      end
   end

   assign full_o  = (cnt_q == LEN);
   assign od_o    = od_q;
   assign oaddr_o = addr_q;
   assign ocen_o  = cen_q;
   assign owen_o  = cen_q;

endmodule

// File: rtl/corelet_ctrl.sv
// Sequencer for one systolic-array operation: weight reads,
// activation reads, then wait for all results to be written.
module corelet_ctrl
   import core_pkg::*;
#(
   parameter int unsigned W_BASE = 0,
   parameter int unsigned W_LEN  = 8,
   parameter int unsigned A_BASE = 8,
   parameter int unsigned A_LEN  = 16,
   parameter int unsigned O_LEN  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            op_done,
   output logic [I_AW-1:0] I_ADDR,
   output logic            I_CEN,
   output logic            I_WEN,
   output logic            arr_load,
   output logic            arr_exec,
   input  logic            arr_out_valid,
   input  logic [O_DW-1:0] arr_out_data,
   output logic [O_DW-1:0] O_D,
   output logic [O_AW-1:0] O_ADDR,
   output logic            O_CEN,
   output logic            O_WEN
);

   localparam logic [I_AW-1:0] W_FIRST = I_AW'(W_BASE);
   localparam logic [I_AW-1:0] W_LAST  = I_AW'(W_BASE + W_LEN - 1);
   localparam logic [I_AW-1:0] A_FIRST = I_AW'(A_BASE);
   localparam logic [I_AW-1:0] A_LAST  = I_AW'(A_BASE + A_LEN - 1);

   state_e          state_q, state_d;
   logic [I_AW-1:0] rd_q, rd_d;
   logic            icen_q, ld_q, ex_q, done_q;
   logic            clr, busy, full;

   assign busy = (state_q == S_LOAD_W) | (state_q == S_EXEC_A)
               | (state_q == S_DRAIN);

   // next state and read counter
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      clr     = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LOAD_W;
               rd_d    = W_FIRST;
               clr     = 1'b1;
            end
         end
         S_LOAD_W: begin
            if (rd_q == W_LAST) begin
               state_d = S_EXEC_A;
               rd_d    = A_FIRST;
            end else begin
               rd_d = rd_q + 1'b1;
            end
         end
         S_EXEC_A: begin
            if (rd_q == A_LAST) state_d = S_DRAIN;
            else                rd_d    = rd_q + 1'b1;
         end
         S_DRAIN: begin
            if (full) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state, read counter and registered read-side outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         rd_q    <= '0;
         icen_q  <= EN_OFF;
         ld_q    <= 1'b0;
         ex_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         icen_q  <= ((state_d == S_LOAD_W) | (state_d == S_EXEC_A))
                    ? EN_ON : EN_OFF;
         ld_q    <= (state_q == S_LOAD_W);
         ex_q    <= (state_q == S_EXEC_A);
         done_q  <= (state_d == S_DONE);
      end
   end

   o_wr_port #(
      .O_LEN(O_LEN)
   ) u_wr (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (clr),
      .en_i   (busy),
      .vld_i  (arr_out_valid),
      .data_i (arr_out_data),
      .full_o (full),
      .od_o   (O_D),
      .oaddr_o(O_ADDR),
      .ocen_o (O_CEN),
      .owen_o (O_WEN)
   );

   assign I_ADDR   = rd_q;
   assign I_CEN    = icen_q;
   assign I_WEN    = EN_OFF;
   assign arr_load = ld_q;
   assign arr_exec = ex_q;
   assign op_done  = done_q;

endmodule
